// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - fully-connected layer sequencer feeding mlp_compute_datapath
module mlp_layer_sequencer #(
  parameter int LANES    = 8,
  parameter int CHUNK_W  = 4,
  parameter int NEURON_W = 6,
  parameter int WADDR_W  = 10,
  parameter int SETTLE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CHUNK_W-1:0]    cfg_chunks,
  input  logic [NEURON_W-1:0]   cfg_neurons,
  input  logic [1:0]            cfg_act_type,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [CHUNK_W-1:0]    in_rd_addr,
  input  logic [LANES*8-1:0]    in_rd_data,
  output logic [WADDR_W-1:0]    w_rd_addr,
  input  logic [LANES*8-1:0]    w_rd_data,
  output logic [NEURON_W-1:0]   b_rd_addr,
  input  logic [7:0]            b_rd_data,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic [LANES*8-1:0]    data_out,
  output logic [LANES*8-1:0]    weight_out,
  output logic [7:0]            bias_out,
  output logic                  activation_enable,
  output logic [1:0]            activation_type,
  input  logic                  mac_valid,
  input  logic                  result_valid,
  input  logic [7:0]            result_in,
  output logic                  res_wr_en,
  output logic [NEURON_W-1:0]   res_wr_addr,
  output logic [7:0]            res_wr_data
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLEAR    = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_LOAD     = 4'd3;
  localparam logic [3:0] S_ISSUE    = 4'd4;
  localparam logic [3:0] S_WAIT_MAC = 4'd5;
  localparam logic [3:0] S_ACT      = 4'd6;
  localparam logic [3:0] S_WAIT_ACT = 4'd7;
  localparam logic [3:0] S_WRITE    = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [1:0] SETTLE_CNT = SETTLE[1:0];

  logic [3:0]          state_q, state_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [WADDR_W-1:0]  wptr_q, wptr_d;
  logic [CHUNK_W-1:0]  n_chunks_q, n_chunks_d;
  logic [NEURON_W-1:0] n_neurons_q, n_neurons_d;
  logic [1:0]          act_type_q, act_type_d;
  logic                cfg_err_q, cfg_err_d;
  logic [1:0]          settle_q, settle_d;
  logic [LANES*8-1:0]  data_q, data_d;
  logic [LANES*8-1:0]  weight_q, weight_d;
  logic [7:0]          bias_q, bias_d;
  logic [7:0]          res_q, res_d;

  // Next-state and datapath-register update for the layer walk
  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    neuron_d    = neuron_q;
    wptr_d      = wptr_q;
    n_chunks_d  = n_chunks_q;
    n_neurons_d = n_neurons_q;
    act_type_d  = act_type_q;
    cfg_err_d   = cfg_err_q;
    settle_d    = settle_q;
    data_d      = data_q;
    weight_d    = weight_q;
    bias_d      = bias_q;
    res_d       = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_chunks_d  = cfg_chunks;
          n_neurons_d = cfg_neurons;
          act_type_d  = cfg_act_type;
          chunk_d     = '0;
          neuron_d    = '0;
          wptr_d      = '0;
          settle_d    = '0;
          if (cfg_chunks == '0 || cfg_neurons == '0) begin
            // Zero-sized layer: flag it and finish without touching any buffer
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        data_d   = in_rd_data;
        weight_d = w_rd_data;
        bias_d   = b_rd_data;
        state_d  = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_MAC;
      S_WAIT_MAC: begin
        // settle_q == 0 means still waiting for mac_valid; otherwise counting down
        if (settle_q == 2'd0) begin
          if (mac_valid) begin
            settle_d = SETTLE_CNT;
          end
        end else if (settle_q == 2'd1) begin
          settle_d = 2'd0;
          wptr_d   = wptr_q + WADDR_W'(1);
          if (chunk_q == n_chunks_q - CHUNK_W'(1)) begin
            chunk_d = '0;
            state_d = S_ACT;
          end else begin
            chunk_d = chunk_q + CHUNK_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          settle_d = settle_q - 2'd1;
        end
      end
      S_ACT: state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (result_valid) begin
          res_d   = result_in;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        chunk_d = '0;
        if (neuron_q == n_neurons_q - NEURON_W'(1)) begin
          state_d = S_DONE;
        end else begin
          neuron_d = neuron_q + NEURON_W'(1);
          state_d  = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and register storage; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chunk_q     <= '0;
      neuron_q    <= '0;
      wptr_q      <= '0;
      n_chunks_q  <= '0;
      n_neurons_q <= '0;
      act_type_q  <= '0;
      cfg_err_q   <= 1'b0;
      settle_q    <= '0;
      data_q      <= '0;
      weight_q    <= '0;
      bias_q      <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      neuron_q    <= neuron_d;
      wptr_q      <= wptr_d;
      n_chunks_q  <= n_chunks_d;
      n_neurons_q <= n_neurons_d;
      act_type_q  <= act_type_d;
      cfg_err_q   <= cfg_err_d;
      settle_q    <= settle_d;
      data_q      <= data_d;
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      res_q       <= res_d;
    end
  end

  // Strobes are pure state decodes, so they are one cycle wide and mutually exclusive
  always_comb begin
    busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    done              = (state_q == S_DONE);
    cfg_err           = cfg_err_q;
    in_rd_addr        = chunk_q;
    w_rd_addr         = wptr_q;
    b_rd_addr         = neuron_q;
    mac_clear         = (state_q == S_CLEAR);
    mac_enable        = (state_q == S_ISSUE);
    activation_enable = (state_q == S_ACT);
    res_wr_en         = (state_q == S_WRITE);
    res_wr_addr       = (state_q == S_WRITE) ? neuron_q : '0;
    res_wr_data       = (state_q == S_WRITE) ? res_q : '0;
    data_out          = data_q;
    weight_out        = weight_q;
    bias_out          = bias_q;
    activation_type   = act_type_q;
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - scoreboard bench for mlp_layer_sequencer
module tb_mlp_layer_sequencer;

  localparam int SETTLE_P = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_chunks;
  logic [5:0]  cfg_neurons;
  logic [1:0]  cfg_act_type;
  logic        busy, done, cfg_err;
  logic [3:0]  in_rd_addr;
  logic [63:0] in_rd_data;
  logic [9:0]  w_rd_addr;
  logic [63:0] w_rd_data;
  logic [5:0]  b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        mac_clear, mac_enable;
  logic [63:0] data_out, weight_out;
  logic [7:0]  bias_out;
  logic        activation_enable;
  logic [1:0]  activation_type;
  logic        mac_valid;
  logic        result_valid;
  logic [7:0]  result_in;
  logic        res_wr_en;
  logic [5:0]  res_wr_addr;
  logic [7:0]  res_wr_data;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.SETTLE(SETTLE_P)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_chunks(cfg_chunks), .cfg_neurons(cfg_neurons), .cfg_act_type(cfg_act_type),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .mac_clear(mac_clear), .mac_enable(mac_enable),
    .data_out(data_out), .weight_out(weight_out), .bias_out(bias_out),
    .activation_enable(activation_enable), .activation_type(activation_type),
    .mac_valid(mac_valid), .result_valid(result_valid), .result_in(result_in),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Buffers with one-cycle synchronous read
  logic [63:0] in_mem [16];
  logic [63:0] w_mem [1024];
  logic [7:0]  b_mem [64];

  always @(posedge clk) begin
    in_rd_data <= in_mem[in_rd_addr];
    w_rd_data  <= w_mem[w_rd_addr];
    b_rd_data  <= b_mem[b_rd_addr];
  end

  function automatic logic signed [31:0] dot(input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] s;
    logic signed [7:0] x, y;
    s = 0;
    for (int l = 0; l < 8; l++) begin
      x = a[8*l +: 8];
      y = b[8*l +: 8];
      s += x * y;
    end
    return s;
  endfunction

  function automatic logic [7:0] act_fn(input logic signed [31:0] acc, input logic [7:0] bias,
                                        input logic [1:0] t);
    logic signed [31:0] r;
    r = (acc >>> 4) + $signed({{24{bias[7]}}, bias});
    if (t == 2'd1 && r < 0) r = 0;
    return r[7:0];
  endfunction

  function automatic logic [7:0] ref_neuron(input int n, input int ch, input logic [1:0] t);
    logic signed [31:0] acc;
    acc = 0;
    for (int c = 0; c < ch; c++) acc += dot(in_mem[c], w_mem[n*ch + c]);
    return act_fn(acc, b_mem[n], t);
  endfunction

  // Behavioural datapath: accumulate on issue, answer after programmable latencies
  int mac_lat = 2;
  int act_lat = 2;
  int mcnt, acnt;
  logic signed [31:0] acc;
  logic rv_stub, rv_stray;
  logic [7:0] rin_stub;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_valid <= 1'b0; rv_stub <= 1'b0; rin_stub <= 8'd0;
      acc <= 0; mcnt <= 0; acnt <= 0;
    end else begin
      mac_valid <= 1'b0;
      rv_stub   <= 1'b0;
      if (mac_clear) acc <= 0;
      if (mac_enable) begin
        acc <= acc + dot(data_out, weight_out);
        if (mac_lat <= 1) mac_valid <= 1'b1; else mcnt <= mac_lat - 1;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) mac_valid <= 1'b1;
      end
      if (activation_enable) begin
        rin_stub <= act_fn(acc, bias_out, activation_type);
        if (act_lat <= 1) rv_stub <= 1'b1; else acnt <= act_lat - 1;
      end else if (acnt != 0) begin
        acnt <= acnt - 1;
        if (acnt == 1) rv_stub <= 1'b1;
      end
    end
  end

  assign result_valid = rv_stub | rv_stray;
  assign result_in    = rv_stray ? 8'hEE : rin_stub;

  // Scoreboard and protocol monitor
  logic [15:0] exp_waddr [$];
  logic [15:0] exp_baddr [$];
  logic [15:0] exp_wr [$];
  int cyc = 0, clr_cnt = 0, en_cnt = 0, act_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int excl_err = 0, stab_err = 0;
  int mv_cyc = 0, since_mv = -1;
  logic mv_pending = 1'b0, in_win = 1'b0;
  logic [3:0] prev_p = 4'd0, p;
  logic [135:0] snap;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_p = 4'd0; in_win = 1'b0; mv_pending = 1'b0;
    end else begin
      p = {mac_clear, mac_enable, activation_enable, res_wr_en};
      if ($countones(p) > 1 || (p & prev_p) != 4'd0) excl_err++;
      prev_p = p;
      if (mac_clear) begin
        clr_cnt++;
        if (exp_baddr.size() == 0) check_eq("b_addr_extra", 1, 0);
        else check_eq("b_rd_addr", {58'd0, b_rd_addr}, {48'd0, exp_baddr.pop_front()});
      end
      if (mac_enable) begin
        en_cnt++;
        if (exp_waddr.size() == 0) check_eq("w_addr_extra", 1, 0);
        else check_eq("w_rd_addr", {54'd0, w_rd_addr}, {48'd0, exp_waddr.pop_front()});
        if (mv_pending) check_eq("issue_gap", 64'(cyc - mv_cyc), 64'(SETTLE_P + 3));
        mv_pending = 1'b0;
        snap = {data_out, weight_out, bias_out};
        in_win = 1'b1;
        since_mv = -1;
      end else if (in_win) begin
        if (snap != {data_out, weight_out, bias_out}) stab_err++;
        if (mac_valid && since_mv < 0) begin
          since_mv = 0; mv_cyc = cyc; mv_pending = 1'b1;
        end else if (since_mv >= 0) begin
          since_mv++;
        end
        if (since_mv >= SETTLE_P) in_win = 1'b0;
      end
      if (activation_enable) begin
        act_cnt++;
        if (mv_pending) check_eq("act_gap", 64'(cyc - mv_cyc), 64'(SETTLE_P + 1));
        mv_pending = 1'b0;
      end
      if (res_wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) check_eq("wr_extra", 1, 0);
        else check_eq("res_wr", {48'd0, 2'b00, res_wr_addr, res_wr_data}, {48'd0, exp_wr.pop_front()});
      end
      if (done) done_cnt++;
    end
  end

  task automatic launch(input int ch, input int nn, input logic [1:0] t);
    cfg_chunks   = 4'(ch);
    cfg_neurons  = 6'(nn);
    cfg_act_type = t;
    for (int n = 0; n < nn; n++) begin
      exp_baddr.push_back(16'(n));
      for (int c = 0; c < ch; c++) exp_waddr.push_back(16'(n*ch + c));
      exp_wr.push_back({8'(n), ref_neuron(n, ch, t)});
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base, k;
    base = done_cnt; k = 0;
    while (done_cnt == base && k < 5000) begin @(negedge clk); k++; end
    check_eq({tag, "_done"}, 64'(done_cnt - base), 64'd1);
    @(negedge clk);
    check_eq({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_done_width"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_sb_left"}, 64'(exp_wr.size() + exp_waddr.size() + exp_baddr.size()), 64'd0);
  endtask

  function automatic int out_ones();
    return $countones({busy, done, cfg_err, in_rd_addr, w_rd_addr, b_rd_addr, mac_clear,
                       mac_enable, data_out, weight_out, bias_out, activation_enable,
                       activation_type, res_wr_en, res_wr_addr, res_wr_data});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_clr, b_en, b_wr, b_act, b_done, seen, k;
    rst = 1'b1; start = 1'b0; rv_stray = 1'b0;
    cfg_chunks = '0; cfg_neurons = '0; cfg_act_type = '0;
    for (int i = 0; i < 16; i++) in_mem[i] = '0;
    for (int i = 0; i < 1024; i++) w_mem[i] = '0;
    for (int i = 0; i < 64; i++) b_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 64'(out_ones()), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1 neuron x 1 chunk, 0x10 everywhere -> 0x80 at address 0
    in_mem[0] = {8{8'h10}}; w_mem[0] = {8{8'h10}}; b_mem[0] = 8'h00;
    b_wr = wr_cnt;
    launch(1, 1, 2'd0);
    check_eq("t1_busy", {63'd0, busy}, 64'd1);
    wait_done("t1");
    check_eq("t1_writes", 64'(wr_cnt - b_wr), 64'd1);

    // 3 neurons x 2 chunks, weight word k = k, relu with one negative pre-activation
    in_mem[0] = {8{8'h01}}; in_mem[1] = {8{8'h02}};
    for (int i = 0; i < 6; i++) w_mem[i] = {8{8'(i)}};
    b_mem[0] = 8'h03; b_mem[1] = 8'hC0; b_mem[2] = 8'h05;
    b_clr = clr_cnt; b_en = en_cnt; b_wr = wr_cnt;
    launch(2, 3, 2'd1);
    wait_done("t2");
    check_eq("t2_mac_enable", 64'(en_cnt - b_en), 64'd6);
    check_eq("t2_mac_clear", 64'(clr_cnt - b_clr), 64'd3);
    check_eq("t2_writes", 64'(wr_cnt - b_wr), 64'd3);

    // Zero chunk count -> error, done next cycle, no strobes; then a valid start clears it
    b_clr = clr_cnt; b_en = en_cnt; b_wr = wr_cnt; b_act = act_cnt;
    cfg_chunks = 4'd0; cfg_neurons = 6'd2; cfg_act_type = 2'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("t3_done", {63'd0, done}, 64'd1);
    check_eq("t3_err", {63'd0, cfg_err}, 64'd1);
    check_eq("t3_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_eq("t3_done_low", {63'd0, done}, 64'd0);
    repeat (5) @(negedge clk);
    check_eq("t3_strobes", 64'((clr_cnt - b_clr) + (en_cnt - b_en) + (wr_cnt - b_wr) + (act_cnt - b_act)), 64'd0);
    check_eq("t3_err_held", {63'd0, cfg_err}, 64'd1);
    launch(1, 1, 2'd0);
    check_eq("t3_err_clear", {63'd0, cfg_err}, 64'd0);
    wait_done("t3");

    // Re-start and stray result_valid during WAIT_MAC are ignored
    mac_lat = 4;
    b_en = en_cnt; b_wr = wr_cnt;
    launch(2, 2, 2'd0);
    k = 0;
    while (!mac_enable && k < 200) begin @(negedge clk); k++; end
    check_eq("t4_issue_seen", {63'd0, mac_enable}, 64'd1);
    @(negedge clk);
    cfg_chunks = 4'd1; cfg_neurons = 6'd1;
    start = 1'b1; rv_stray = 1'b1;
    @(negedge clk);
    start = 1'b0; rv_stray = 1'b0;
    wait_done("t4");
    check_eq("t4_writes", 64'(wr_cnt - b_wr), 64'd2);
    check_eq("t4_mac_enable", 64'(en_cnt - b_en), 64'd4);

    // Slow MAC with SETTLE=2: gaps checked by monitor, operands held through WAIT_MAC
    mac_lat = 5;
    launch(3, 2, 2'd0);
    wait_done("t5");
    check_eq("t5_stable", 64'(stab_err), 64'd0);
    mac_lat = 2;

    // Reset during WAIT_ACT of neuron 1 aborts; fresh run afterwards
    act_lat = 6;
    launch(1, 3, 2'd0);
    seen = 0; k = 0;
    while (seen < 2 && k < 500) begin
      @(negedge clk); k++;
      if (activation_enable) seen++;
    end
    check_eq("t6_act_seen", 64'(seen), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_outs", 64'(out_ones()), 64'd0);
    b_wr = wr_cnt; b_done = done_cnt;
    exp_wr.delete(); exp_waddr.delete(); exp_baddr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_no_write", 64'(wr_cnt - b_wr), 64'd0);
    check_eq("t6_no_done", 64'(done_cnt - b_done), 64'd0);
    check_eq("t6_idle_busy", {63'd0, busy}, 64'd0);
    act_lat = 2;
    b_wr = wr_cnt;
    launch(2, 3, 2'd0);
    wait_done("t6");
    check_eq("t6_writes", 64'(wr_cnt - b_wr), 64'd3);

    check_eq("excl_strobes", 64'(excl_err), 64'd0);
    check_eq("operand_stable", 64'(stab_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
